// File: rtl/adc_frame_fifo.sv
// Sample FIFO between the ADC and the AR9331 byte-link sender. It starts the sender
// once a full frame is queued and presents the queue head first-word-fall-through.
module adc_frame_fifo #(
  parameter int DW        = 8,
  parameter int AW        = 6,
  parameter int FRAME_LEN = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic          link_busy,
  input  logic          link_pop,
  output logic          frame_en,
  output logic [DW-1:0] link_data,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          underflow,
  output logic [1:0]    state_dbg
);

  // Handshake: a push is accepted when adc_valid && arm && !full; a pop is accepted
  // when link_pop && !empty. Both are sampled on the same rising edge, and full/empty
  // are always taken from the pointers before that edge.

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FLEN = (AW+1)'(FRAME_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_START = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   pop_cnt, pop_cnt_nxt;
  logic          arm_q;
  logic          full, empty, do_wr, do_rd, arm_rise;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_wr    = adc_valid && arm && !full;
  assign do_rd    = link_pop && !empty;
  assign arm_rise = arm && !arm_q;

  // Pointer difference is exact because the pointers carry one extra wrap bit.
  assign level     = wr_ptr - rd_ptr;
  assign link_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign frame_en  = (state == S_START);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= adc_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A new error in the same cycle as a re-arm wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      arm_q <= arm;
      if (arm_rise) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (adc_valid && arm && full) overflow  <= 1'b1;
      if (link_pop && empty)        underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pop_cnt <= pop_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pop_cnt_nxt = pop_cnt;
    case (state)
      S_IDLE: begin
        pop_cnt_nxt = '0;
        if (arm) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        pop_cnt_nxt = '0;
        if (!arm)                                state_nxt = S_IDLE;
        else if ((level >= FLEN) && !link_busy) state_nxt = S_START;
      end
      S_START: begin
        pop_cnt_nxt = '0;
        if (link_busy) state_nxt = S_SEND;
      end
      S_SEND: begin
        // Disarming never aborts a frame; it only selects where we land afterwards.
        if (do_rd && (pop_cnt != FLEN)) pop_cnt_nxt = pop_cnt + 1'b1;
        if ((pop_cnt == FLEN) && !link_busy) state_nxt = arm ? S_WAIT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_frame_fifo.sv
// Bench for adc_frame_fifo: drives ADC pushes and sender pops, and checks every output
// cycle against a queue model of the FIFO contents and the sticky flags.
module tb_adc_frame_fifo;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          link_busy = 1'b0;
  logic          link_pop = 1'b0;
  logic          frame_en;
  logic [DW-1:0] link_data;
  logic [AW:0]   level;
  logic          overflow, underflow;
  logic [1:0]    state_dbg;

  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  int            n_tests = 0;
  int            n_fail  = 0;

  adc_frame_fifo #(.DW(DW), .AW(AW), .FRAME_LEN(6)) dut (
    .clk(clk), .rst(rst), .arm(arm), .adc_data(adc_data), .adc_valid(adc_valid),
    .link_busy(link_busy), .link_pop(link_pop), .frame_en(frame_en),
    .link_data(link_data), .level(level), .overflow(overflow),
    .underflow(underflow), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; adc_valid = 1'b0; link_pop = 1'b0; link_busy = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock of optional push and/or pop, followed by scoreboard checks.
  task automatic xfer(input bit p, input bit q, input logic [DW-1:0] d);
    bit full_m  = (exp_q.size() == DEPTH);
    bit empty_m = (exp_q.size() == 0);
    if (q && !empty_m) check("head", link_data, exp_q[0]);
    adc_valid = p; adc_data = d; link_pop = q;
    step();
    adc_valid = 1'b0; link_pop = 1'b0;
    if (q) begin
      if (empty_m) m_unf = 1'b1;
      else void'(exp_q.pop_front());
    end
    if (p && arm) begin
      if (full_m) m_ovf = 1'b1;
      else exp_q.push_back(d);
    end
    check("level", level, exp_q.size());
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
    if (exp_q.size() == 0) check("empty_data", link_data, 0);
    else                   check("head_vis", link_data, exp_q[0]);
  endtask

  task automatic wait_frame_en();
    for (int i = 0; i < 10 && !frame_en; i++) xfer(0, 0, 0);
    check("frame_en_wait", frame_en, 1);
  endtask

  initial begin
    // reset state
    step();
    check("rst_frame_en", frame_en, 0);
    check("rst_level", level, 0);
    check("rst_data", link_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_state", state_dbg, 0);
    do_reset();

    // T2 frame
    arm = 1'b1;
    xfer(0, 0, 0);
    check("t2_wait", state_dbg, 1);
    for (int i = 0; i < 6; i++) xfer(1, 0, 8'h10 + 8'(i));
    check("t2_fe_lvl6", frame_en, 0);
    xfer(0, 0, 0);
    check("t2_fe_rise", frame_en, 1);
    link_busy = 1'b1;
    xfer(0, 0, 0);
    check("t2_fe_fall", frame_en, 0);
    check("t2_send", state_dbg, 3);
    for (int i = 0; i < 6; i++) begin
      check("t2_byte", link_data, 8'h10 + 8'(i));
      xfer(0, 1, 0);
    end
    check("t2_still_send", state_dbg, 3);
    link_busy = 1'b0;
    xfer(0, 0, 0);
    check("t2_back_wait", state_dbg, 1);

    // T3 full, then T5 simultaneous at full
    do_reset();
    arm = 1'b1;
    for (int i = 0; i < 65; i++) xfer(1, 0, 8'(i + 100));
    check("t3_level64", level, 64);
    check("t3_ovf", overflow, 1);
    xfer(1, 1, 8'hEE);
    check("t5_full_lvl", level, 63);
    check("t5_full_ovf", overflow, 1);
    for (int i = 0; i < 63; i++) xfer(0, 1, 0);
    check("t3_drained", level, 0);

    // T5 simultaneous at empty
    xfer(1, 1, 8'h5A);
    check("t5_empty_lvl", level, 1);
    check("t5_empty_unf", underflow, 1);
    check("t5_empty_data", link_data, 8'h5A);
    xfer(0, 1, 0);

    // T4 random traffic across the pointer wrap
    do_reset();
    arm = 1'b1;
    for (int i = 0; i < 300; i++)
      xfer($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
    while (exp_q.size() != 0) xfer(0, 1, 0);

    // T6 disarm during SEND
    do_reset();
    arm = 1'b1;
    xfer(0, 0, 0);
    for (int i = 0; i < 6; i++) xfer(1, 0, 8'hC0 + 8'(i));
    wait_frame_en();
    link_busy = 1'b1;
    xfer(0, 0, 0);
    check("t6_send", state_dbg, 3);
    arm = 1'b0;
    for (int i = 0; i < 6; i++) xfer(0, 1, 0);
    check("t6_still_send", state_dbg, 3);
    link_busy = 1'b0;
    xfer(0, 0, 0);
    check("t6_idle", state_dbg, 0);
    xfer(1, 0, 8'hAA);
    check("t6_ignored_lvl", level, 0);
    check("t6_no_ovf", overflow, 0);
    check("t6_fe_low", frame_en, 0);

    // T1 asynchronous reset mid-SEND
    do_reset();
    arm = 1'b1;
    xfer(0, 0, 0);
    for (int i = 0; i < 6; i++) xfer(1, 0, 8'h30 + 8'(i));
    wait_frame_en();
    link_busy = 1'b1;
    xfer(0, 0, 0);
    xfer(0, 1, 0);
    xfer(0, 1, 0);
    check("t1_pre_send", state_dbg, 3);
    check("t1_pre_lvl", level, 4);
    #2 rst = 1'b1;
    #1;
    check("t1_frame_en", frame_en, 0);
    check("t1_level", level, 0);
    check("t1_data", link_data, 0);
    check("t1_ovf", overflow, 0);
    check("t1_unf", underflow, 0);
    check("t1_state", state_dbg, 0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
